// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the functional-unit write-back path: per-FU result record,
// the slimmer CDB broadcast record, and the default producer count.
package cdb_arbiter_pkg;

  localparam int NUM_FU_CDB = 4;
  localparam int ROB_ID_W   = 6;
  localparam int ARCH_REG_W = 5;
  localparam int PHY_REG_W  = 7;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [ROB_ID_W-1:0]   rob_id;
    logic [ARCH_REG_W-1:0] rd_arch;
    logic [PHY_REG_W-1:0]  rd_phy;
    logic [XLEN-1:0]       rd_value;
    logic [XLEN-1:0]       rs1_value_dbg;
    logic [XLEN-1:0]       rs2_value_dbg;
  } fu_cdb_reg_t;

  typedef struct packed {
    logic [ROB_ID_W-1:0]   rob_id;
    logic [ARCH_REG_W-1:0] rd_arch;
    logic [PHY_REG_W-1:0]  rd_phy;
    logic [XLEN-1:0]       rd_value;
  } cdb_t;

  // Debug operand values never leave the FU; only completion fields go on the bus.
  function automatic cdb_t to_cdb(input fu_cdb_reg_t r);
    cdb_t c;
    c.rob_id   = r.rob_id;
    c.rd_arch  = r.rd_arch;
    c.rd_phy   = r.rd_phy;
    c.rd_value = r.rd_value;
    return c;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping
// at N-1 -> 0. Shared with the issue select logic.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W-1:0] k;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int d);
    int s;
    s = (int'(p) + d) % N;
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = '0;
    for (int d = 0; d < N; d++) begin
      k = wrap_add(ptr, d);
      if (!any && req[k]) begin
        any    = 1'b1;
        idx    = k;
        gnt[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Write-back arbiter: one FU result per cycle, round-robin, onto a registered
// common data bus with no backpressure.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int NUM_FU = NUM_FU_CDB,
  localparam int PTR_W  = $clog2(NUM_FU)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NUM_FU-1:0]        fu_valid,
  output logic [NUM_FU-1:0]        fu_ready,
  input  fu_cdb_reg_t [NUM_FU-1:0] fu_cdb,
  output logic                     cdb_valid,
  output cdb_t                     cdb_out,
  output logic                     cdb_rd_we
);

  logic [PTR_W-1:0]  rr_ptr;
  logic [NUM_FU-1:0] gnt_p0;
  logic [PTR_W-1:0]  win_p0;
  logic              any_p0;
  logic              xfer_p0;
  logic              vld_p1;
  cdb_t              cdb_p1;
  logic              unused_dbg;

  rr_arbiter #(.N(NUM_FU)) u_rr (
    .req (fu_valid),
    .ptr (rr_ptr),
    .gnt (gnt_p0),
    .idx (win_p0),
    .any (any_p0)
  );

  // Stage 0: combinational grant; held at zero in reset and during flush.
  assign fu_ready = (rst_n && !flush) ? gnt_p0 : '0;
  assign xfer_p0  = any_p0 && !flush;
  assign unused_dbg = ^fu_cdb;

  // Stage 1: registered broadcast; pointer wraps explicitly for non-power-of-two NUM_FU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      cdb_p1 <= '0;
      rr_ptr <= '0;
    end else begin
      vld_p1 <= xfer_p0;
      if (xfer_p0) begin
        cdb_p1 <= to_cdb(fu_cdb[win_p0]);
        rr_ptr <= (win_p0 == PTR_W'(NUM_FU - 1)) ? '0 : win_p0 + 1'b1;
      end
    end
  end

  assign cdb_valid = vld_p1;
  assign cdb_out   = cdb_p1;
  assign cdb_rd_we = vld_p1 && (cdb_p1.rd_arch != '0);

endmodule
